// File: rtl/div_repsub_if.sv
// Operand/result bundle for the repeated-subtraction divider.
// The requester drives start and the shared data_in bus; the divider returns status and results.
interface div_repsub_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] data_in;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;

  modport master (
    output start, data_in,
    input  busy, done, div_by_zero, quotient, remainder
  );

  modport slave (
    input  start, data_in,
    output busy, done, div_by_zero, quotient, remainder
  );
endinterface

// File: rtl/div_repsub_unit.sv
// Sequential unsigned divider by repeated subtraction. The dividend is taken with start and
// the divisor on the following cycle from the same bus; results are held until the next completion.
module div_repsub_unit #(
  parameter int WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  div_repsub_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOADB = 3'd1,
    S_CHECK = 3'd2,
    S_SUB   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           state_r;
  state_t           next_state_s;
  logic [WIDTH-1:0] rem_work_r;
  logic [WIDTH-1:0] divisor_r;
  logic [WIDTH-1:0] quot_work_r;
  logic [WIDTH-1:0] quotient_r;
  logic [WIDTH-1:0] remainder_r;
  logic             div_by_zero_r;
  logic             busy_s;
  logic             done_s;
  logic             divisor_zero_s;
  logic             can_sub_s;

  assign divisor_zero_s = (divisor_r == {WIDTH{1'b0}});
  assign can_sub_s      = (rem_work_r >= divisor_r);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (bus.start) begin
          next_state_s = S_LOADB;
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_LOADB: next_state_s = S_CHECK;
      S_CHECK: begin
        if (divisor_zero_s) begin
          next_state_s = S_DONE;
        end else begin
          next_state_s = S_SUB;
        end
      end
      S_SUB: begin
        if (can_sub_s) begin
          next_state_s = S_SUB;
        end else begin
          next_state_s = S_DONE;
        end
      end
      S_DONE:  next_state_s = S_IDLE;
      default: next_state_s = S_IDLE;
    endcase
  end

  // Status decode from the state register.
  always_comb begin
    busy_s = 1'b0;
    done_s = 1'b0;
    case (state_r)
      S_LOADB, S_CHECK, S_SUB: busy_s = 1'b1;
      S_DONE:                  done_s = 1'b1;
      default: begin
        busy_s = 1'b0;
        done_s = 1'b0;
      end
    endcase
  end

  // Datapath: operand capture, subtract loop and result latching on entry to DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_work_r    <= {WIDTH{1'b0}};
      divisor_r     <= {WIDTH{1'b0}};
      quot_work_r   <= {WIDTH{1'b0}};
      quotient_r    <= {WIDTH{1'b0}};
      remainder_r   <= {WIDTH{1'b0}};
      div_by_zero_r <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (bus.start) begin
            rem_work_r    <= bus.data_in;
            quot_work_r   <= {WIDTH{1'b0}};
            div_by_zero_r <= 1'b0;
          end
        end
        S_LOADB: divisor_r <= bus.data_in;
        S_CHECK: begin
          // Zero divisor reports all-ones quotient and passes the dividend through.
          if (divisor_zero_s) begin
            quotient_r    <= {WIDTH{1'b1}};
            remainder_r   <= rem_work_r;
            div_by_zero_r <= 1'b1;
          end
        end
        S_SUB: begin
          if (can_sub_s) begin
            rem_work_r  <= rem_work_r - divisor_r;
            quot_work_r <= quot_work_r + {{(WIDTH-1){1'b0}}, 1'b1};
          end else begin
            quotient_r  <= quot_work_r;
            remainder_r <= rem_work_r;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.busy        = busy_s;
  assign bus.done        = done_s;
  assign bus.div_by_zero = div_by_zero_r;
  assign bus.quotient    = quotient_r;
  assign bus.remainder   = remainder_r;

endmodule
